cellrv32_cpu_cp_vector_wbarb: RTL

//  Write-back arbiter for the vector register file element write port. Shares the single
//  per-element write port of the vector issue stage between the vector execution unit (EX)
//  and the vector memory unit (MEM). Round-robin grant, same-register merge of disjoint lane

---
 rtl/cellrv32_cpu_cp_vector_wbarb.sv | 87 ++++++++
 1 files changed

// File: rtl/cellrv32_cpu_cp_vector_wbarb.sv
// cellrv32_cpu_cp_vector_wbarb: round-robin write-back arbiter between vector EX and MEM
// units for the shared VRF element write port, with same-register lane-mask merging.
module cellrv32_cpu_cp_vector_wbarb #(
    parameter int VECTOR_REGISTERS = 32,
    parameter int VECTOR_LANES     = 8,
    parameter int DATA_WIDTH       = 32,
    localparam int AW = $clog2(VECTOR_REGISTERS),
    localparam int L  = VECTOR_LANES,
    localparam int D  = L * DATA_WIDTH
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          flush_i,
    input  logic          ex_valid_i,
    output logic          ex_ready_o,
    input  logic [L-1:0]  ex_mask_i,
    input  logic [AW-1:0] ex_addr_i,
    input  logic [D-1:0]  ex_data_i,
    input  logic          mem_valid_i,
    output logic          mem_ready_o,
    input  logic [L-1:0]  mem_mask_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [D-1:0]  mem_data_i,
    input  logic          mem_unlock_i,
    output logic [L-1:0]  wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [D-1:0]  wr_data_o,
    output logic          unlock_en_o,
    output logic [AW-1:0] unlock_reg_o,
    output logic          busy_o
);
    typedef enum logic {PTR_EX, PTR_MEM} ptr_t;

    ptr_t          ptr_q, ptr_d;
    logic [L-1:0]  wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [D-1:0]  wr_data_q, wr_data_d;
    logic          unlock_en_q, unlock_en_d;
    logic [AW-1:0] unlock_reg_q, unlock_reg_d;
    logic          both, merge, ex_gnt, mem_gnt;

    always_comb begin
        both    = ex_valid_i && mem_valid_i;
        merge   = both && (ex_addr_i == mem_addr_i) && ((ex_mask_i & mem_mask_i) == '0);
        ex_gnt  = !flush_i && ex_valid_i && (!mem_valid_i || merge || ptr_q == PTR_EX);
        mem_gnt = !flush_i && mem_valid_i && (!ex_valid_i || merge || ptr_q == PTR_MEM);
        // a contested single grant hands priority to whoever lost
        ptr_d   = flush_i ? PTR_EX : (both && !merge) ? (ex_gnt ? PTR_MEM : PTR_EX) : ptr_q;
        wr_en_d   = (ex_gnt ? ex_mask_i : '0) | (mem_gnt ? mem_mask_i : '0);
        wr_addr_d = ex_gnt ? ex_addr_i : mem_gnt ? mem_addr_i : wr_addr_q;
        for (int k = 0; k < L; k++) begin
            wr_data_d[k*DATA_WIDTH +: DATA_WIDTH] =
                (mem_gnt && (!ex_gnt || mem_mask_i[k])) ? mem_data_i[k*DATA_WIDTH +: DATA_WIDTH] :
                ex_gnt ? ex_data_i[k*DATA_WIDTH +: DATA_WIDTH] : wr_data_q[k*DATA_WIDTH +: DATA_WIDTH];
        end
        unlock_en_d  = mem_gnt && mem_unlock_i;
        unlock_reg_d = mem_gnt ? mem_addr_i : unlock_reg_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_q        <= PTR_EX;
            wr_en_q      <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            unlock_en_q  <= 1'b0;
            unlock_reg_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            unlock_en_q  <= unlock_en_d;
            unlock_reg_q <= unlock_reg_d;
        end
    end

    // nothing is accepted while reset is held
    assign ex_ready_o   = ex_gnt && rstn_i;
    assign mem_ready_o  = mem_gnt && rstn_i;
    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign unlock_en_o  = unlock_en_q;
    assign unlock_reg_o = unlock_reg_q;
    assign busy_o       = ex_valid_i || mem_valid_i || (|wr_en_q);
endmodule
